snn_config_loader: RTL and testbench

//   Byte-stream configuration writer for SNNwithDelays_top (the 8|8|8 network, 2-bit weights, 6-bit potentials).

---
 rtl/snn_cfg_pkg.sv | 60 ++++++
 rtl/snn_cfg_bank.sv | 103 ++++++++++
 rtl/snn_config_loader.sv | 135 +++++++++++++
 tb/tb_snn_config_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the SNN configuration loader.
//   - Command opcode and region codes carried in the command byte.
//   - Region lengths and byte offsets inside the combined "all" byte map.
//   - Live bus widths shared with the network top level.
//   - FSM state encoding and small helpers for region length and base offset.
package snn_cfg_pkg;

   localparam logic [1:0] OP_WRITE = 2'b01;

   localparam logic [1:0] REG_W   = 2'd0;
   localparam logic [1:0] REG_D   = 2'd1;
   localparam logic [1:0] REG_P   = 2'd2;
   localparam logic [1:0] REG_ALL = 2'd3;

   localparam int W_BYTES = 32;
   localparam int D_BYTES = 64;
   localparam int P_BYTES = 3;

   // Byte offsets of each region within the combined map (region 3 order).
   localparam logic [6:0] W_OFF = 7'd0;
   localparam logic [6:0] D_OFF = 7'd32;
   localparam logic [6:0] P_OFF = 7'd96;

   localparam int W_BITS = W_BYTES * 8;
   localparam int D_BITS = D_BYTES * 8;
   localparam int PW     = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Number of payload bytes that follow a command for the given region.
   function automatic logic [6:0] region_len(input logic [1:0] region);
      logic [6:0] len;
      case (region)
         REG_W:   len = 7'd32;
         REG_D:   len = 7'd64;
         REG_P:   len = 7'd3;
         REG_ALL: len = 7'd99;
         default: len = 7'd99;
      endcase
      return len;
   endfunction

   // Offset of payload byte 0 of a region inside the combined byte map.
   function automatic logic [6:0] region_base(input logic [1:0] region);
      logic [6:0] base;
      case (region)
         REG_W:   base = W_OFF;
         REG_D:   base = D_OFF;
         REG_P:   base = P_OFF;
         REG_ALL: base = W_OFF;
         default: base = W_OFF;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/snn_cfg_bank.sv
// Staging plus live configuration registers.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : write one byte into staging; wr_addr is the offset
//                         in the combined map (0..31 weights, 32..95 delays,
//                         96..98 threshold/decay/refractory)
//   commit_w/d/p        : copy the staging region to live. A commit issued with
//                         the final byte of a load already includes that byte,
//                         so the live buses change atomically one edge later.
//   weights, delays, threshold, decay, refractory_period : live buses
module snn_cfg_bank
   import snn_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [6:0]        wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              commit_w,
   input  logic              commit_d,
   input  logic              commit_p,
   output logic [W_BITS-1:0] weights,
   output logic [D_BITS-1:0] delays,
   output logic [PW-1:0]     threshold,
   output logic [PW-1:0]     decay,
   output logic [PW-1:0]     refractory_period
);

   logic [W_BITS-1:0] w_stage_r, w_next_s;
   logic [D_BITS-1:0] d_stage_r, d_next_s;
   logic [PW-1:0]     th_stage_r, th_next_s;
   logic [PW-1:0]     dc_stage_r, dc_next_s;
   logic [PW-1:0]     rf_stage_r, rf_next_s;
   logic [5:0]        d_idx_s;

   // Next staging contents with the incoming byte merged in.
   always_comb begin
      w_next_s  = w_stage_r;
      d_next_s  = d_stage_r;
      th_next_s = th_stage_r;
      dc_next_s = dc_stage_r;
      rf_next_s = rf_stage_r;
      // Delay byte index; modulo-64 wrap is exact for offsets 32..95.
      d_idx_s   = wr_addr[5:0] - 6'd32;
      if (wr_en) begin
         if (wr_addr < D_OFF) begin
            w_next_s[{wr_addr[4:0], 3'b000} +: 8] = wr_data;
         end else if (wr_addr < P_OFF) begin
            d_next_s[{d_idx_s, 3'b000} +: 8] = wr_data;
         end else begin
            // Parameter bytes keep only their low six bits.
            case (wr_addr)
               7'd96:   th_next_s = wr_data[5:0];
               7'd97:   dc_next_s = wr_data[5:0];
               7'd98:   rf_next_s = wr_data[5:0];
               default: th_next_s = th_stage_r;
            endcase
         end
      end else begin
         w_next_s = w_stage_r;
      end
   end

   // Staging bank register; never cleared between commands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_stage_r  <= '0;
         d_stage_r  <= '0;
         th_stage_r <= '0;
         dc_stage_r <= '0;
         rf_stage_r <= '0;
      end else begin
         w_stage_r  <= w_next_s;
         d_stage_r  <= d_next_s;
         th_stage_r <= th_next_s;
         dc_stage_r <= dc_next_s;
         rf_stage_r <= rf_next_s;
      end
   end

   // Live registers, updated only for the committed regions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weights           <= '0;
         delays            <= '0;
         threshold         <= '0;
         decay             <= '0;
         refractory_period <= '0;
      end else begin
         if (commit_w) begin
            weights <= w_next_s;
         end
         if (commit_d) begin
            delays <= d_next_s;
         end
         if (commit_p) begin
            threshold         <= th_next_s;
            decay             <= dc_next_s;
            refractory_period <= rf_next_s;
         end
      end
   end

endmodule

// File: rtl/snn_config_loader.sv
// Byte-stream configuration writer for the 8|8|8 SNN network.
//   clk, reset        : clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready : byte input handshake (transfer = valid & ready)
//   weights, delays, threshold, decay, refractory_period : live config buses
//   cfg_busy          : high while loading or committing
//   cfg_done          : one-cycle pulse in the cycle the live buses update
//   cfg_loaded        : sticky, a commit happened since reset
//   cfg_error         : sticky, last command byte was illegal
// A command byte [7:6]=opcode, [1:0]=region selects a payload load into
// staging; the final payload byte commits that region to live in one step.
module snn_config_loader
   import snn_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [W_BITS-1:0] weights,
   output logic [D_BITS-1:0] delays,
   output logic [PW-1:0]     threshold,
   output logic [PW-1:0]     decay,
   output logic [PW-1:0]     refractory_period,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_loaded,
   output logic              cfg_error
);

   state_t     state_r, state_n;
   logic [1:0] region_r, region_n;
   logic [6:0] cnt_r, cnt_n;
   logic       error_n;
   logic       xfer_s;
   logic       wr_en_s;
   logic       last_s;
   logic       commit_w_s, commit_d_s, commit_p_s;
   logic [6:0] wr_addr_s;

   assign xfer_s    = rx_valid & rx_ready;
   assign wr_addr_s = region_base(region_r) + cnt_r;

   // Next-state, counter and strobe logic.
   always_comb begin
      state_n    = state_r;
      region_n   = region_r;
      cnt_n      = cnt_r;
      error_n    = cfg_error;
      wr_en_s    = 1'b0;
      last_s     = 1'b0;
      commit_w_s = 1'b0;
      commit_d_s = 1'b0;
      commit_p_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               if (rx_data[7:6] == OP_WRITE) begin
                  region_n = rx_data[1:0];
                  cnt_n    = 7'd0;
                  error_n  = 1'b0;
                  state_n  = ST_LOAD;
               end else begin
                  error_n = 1'b1;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (xfer_s) begin
               wr_en_s = 1'b1;
               if (cnt_r == region_len(region_r) - 7'd1) begin
                  // Final byte: commit with it so live changes in one step.
                  last_s     = 1'b1;
                  state_n    = ST_COMMIT;
                  commit_w_s = (region_r == REG_W) || (region_r == REG_ALL);
                  commit_d_s = (region_r == REG_D) || (region_r == REG_ALL);
                  commit_p_s = (region_r == REG_P) || (region_r == REG_ALL);
               end else begin
                  cnt_n = cnt_r + 7'd1;
               end
            end else begin
               state_n = ST_LOAD;
            end
         end
         ST_COMMIT: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // FSM state, counter and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         region_r   <= 2'd0;
         cnt_r      <= 7'd0;
         rx_ready   <= 1'b0;
         cfg_busy   <= 1'b0;
         cfg_done   <= 1'b0;
         cfg_loaded <= 1'b0;
         cfg_error  <= 1'b0;
      end else begin
         state_r    <= state_n;
         region_r   <= region_n;
         cnt_r      <= cnt_n;
         // Ready is dropped for exactly the COMMIT cycle.
         rx_ready   <= (state_n != ST_COMMIT);
         cfg_busy   <= (state_n != ST_IDLE);
         cfg_done   <= last_s;
         cfg_loaded <= cfg_loaded | last_s;
         cfg_error  <= error_n;
      end
   end

   snn_cfg_bank u_bank (
      .clk               (clk),
      .reset             (reset),
      .wr_en             (wr_en_s),
      .wr_addr           (wr_addr_s),
      .wr_data           (rx_data),
      .commit_w          (commit_w_s),
      .commit_d          (commit_d_s),
      .commit_p          (commit_p_s),
      .weights           (weights),
      .delays            (delays),
      .threshold         (threshold),
      .decay             (decay),
      .refractory_period (refractory_period)
   );

endmodule

// File: tb/tb_snn_config_loader.sv
// Self-checking bench for snn_config_loader: directed sequences for load,
// commit, error, reset-abort and commit back-pressure, plus a table of
// parameter-region commands.
module tb_snn_config_loader;

   logic         clk;
   logic         reset;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic [255:0] weights;
   logic [511:0] delays;
   logic [5:0]   threshold, decay, refractory_period;
   logic         cfg_busy, cfg_done, cfg_loaded, cfg_error;

   int n_checks;
   int n_fail;

   logic [255:0] exp_w, new_w;
   logic [511:0] exp_d, new_d;
   logic [5:0]   exp_th, exp_dc, exp_rf;

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] p0, p1, p2;
      logic       err;
      logic [5:0] th, dc, rf;
   } vec_t;

   vec_t tbl[6];

   snn_config_loader dut (
      .clk               (clk),
      .reset             (reset),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready),
      .weights           (weights),
      .delays            (delays),
      .threshold         (threshold),
      .decay             (decay),
      .refractory_period (refractory_period),
      .cfg_busy          (cfg_busy),
      .cfg_done          (cfg_done),
      .cfg_loaded        (cfg_loaded),
      .cfg_error         (cfg_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one byte, wait for acceptance, leave 1 ns after the transfer edge.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got rx_ready=0 expected 1 for byte %0h", b);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int done_cnt;
      int busy_low;
      int live_chg;

      n_checks = 0;
      n_fail   = 0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      reset    = 1'b1;
      exp_w = '0; exp_d = '0; exp_th = '0; exp_dc = '0; exp_rf = '0;

      tbl[0] = '{8'h42, 8'hFF, 8'h05, 8'h03, 1'b0, 6'h3F, 6'h05, 6'h03};
      tbl[1] = '{8'hC1, 8'h00, 8'h00, 8'h00, 1'b1, 6'h3F, 6'h05, 6'h03};
      tbl[2] = '{8'h7E, 8'h2A, 8'hC0, 8'h81, 1'b0, 6'h2A, 6'h00, 6'h01};
      tbl[3] = '{8'h02, 8'h00, 8'h00, 8'h00, 1'b1, 6'h2A, 6'h00, 6'h01};
      tbl[4] = '{8'h82, 8'h00, 8'h00, 8'h00, 1'b1, 6'h2A, 6'h00, 6'h01};
      tbl[5] = '{8'h42, 8'h00, 8'h3F, 8'hFF, 1'b0, 6'h00, 6'h3F, 6'h3F};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", rx_ready, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_flags", {cfg_done, cfg_loaded, cfg_error}, 0);
      chk("rst_weights", weights, 0);
      chk("rst_delays", delays, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("ready_after_rst", rx_ready, 1);

      // Test 1: weights region
      send(8'h40);
      chk("t1_busy_load", cfg_busy, 1);
      for (int k = 0; k < 32; k++) begin
         send(k[7:0]);
         exp_w[8*k +: 8] = k[7:0];
         if (k == 30) chk("t1_no_done_early", cfg_done, 0);
      end
      chk("t1_done", cfg_done, 1);
      chk("t1_ready_commit", rx_ready, 0);
      chk("t1_w_lo", weights[7:0], 8'h00);
      chk("t1_w_hi", weights[255:248], 8'h1F);
      chk("t1_weights", weights, exp_w);
      chk("t1_delays", delays, 0);
      tick();
      chk("t1_done_pulse", cfg_done, 0);
      chk("t1_ready_back", rx_ready, 1);
      chk("t1_busy_off", cfg_busy, 0);
      chk("t1_loaded", cfg_loaded, 1);

      // Test 2: parameter-region table with illegal commands mixed in
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].cmd);
         chk("tbl_error", cfg_error, tbl[i].err);
         chk("tbl_busy", cfg_busy, !tbl[i].err);
         if (!tbl[i].err) begin
            send(tbl[i].p0);
            send(tbl[i].p1);
            send(tbl[i].p2);
            chk("tbl_done", cfg_done, 1);
         end
         chk("tbl_params", {threshold, decay, refractory_period},
             {tbl[i].th, tbl[i].dc, tbl[i].rf});
         chk("tbl_weights_kept", weights, exp_w);
         tick();
      end
      exp_th = 6'h00; exp_dc = 6'h3F; exp_rf = 6'h3F;
      chk("t2_loaded", cfg_loaded, 1);

      // Test 4 + 5: illegal, legal, then reset mid-load
      send(8'hC1);
      chk("t4_err_set", cfg_error, 1);
      chk("t4_idle", cfg_busy, 0);
      chk("t4_delays_same", delays, exp_d);
      send(8'h41);
      chk("t4_err_clr", cfg_error, 0);
      chk("t4_load", cfg_busy, 1);
      for (int k = 0; k < 10; k++) send(8'hEE);
      reset = 1'b1;
      #1;
      chk("t5_delays0", delays, 0);
      chk("t5_weights0", weights, 0);
      chk("t5_busy0", cfg_busy, 0);
      chk("t5_loaded0", cfg_loaded, 0);
      chk("t5_params0", {threshold, decay, refractory_period}, 0);
      exp_w = '0; exp_th = '0; exp_dc = '0; exp_rf = '0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      send(8'h41);
      for (int k = 0; k < 64; k++) begin
         send(8'(k * 3 + 1));
         exp_d[8*k +: 8] = 8'(k * 3 + 1);
      end
      chk("t5_done", cfg_done, 1);
      chk("t5_delays", delays, exp_d);
      chk("t5_weights_stay0", weights, 0);
      tick();
      chk("t5_loaded", cfg_loaded, 1);

      // Test 3: region ALL with rx_valid toggling
      send(8'h43);
      done_cnt = 0; busy_low = 0; live_chg = 0;
      new_w = '0; new_d = '0;
      for (int k = 0; k < 99; k++) begin
         logic [7:0] b;
         if (k < 32) begin
            b = 8'hA0 ^ k[7:0];
            new_w[8*k +: 8] = b;
         end else if (k < 96) begin
            b = k[7:0];
            new_d[8*(k-32) +: 8] = b;
         end else begin
            b = (k == 96) ? 8'h11 : (k == 97) ? 8'h22 : 8'hF3;
         end
         send(b);
         if (k < 98) begin
            done_cnt += int'(cfg_done);
            busy_low += int'(!cfg_busy);
            if (weights !== exp_w || delays !== exp_d ||
                {threshold, decay, refractory_period} !== {exp_th, exp_dc, exp_rf})
               live_chg++;
            tick();
            done_cnt += int'(cfg_done);
            busy_low += int'(!cfg_busy);
         end
      end
      chk("t3_no_early_done", done_cnt, 0);
      chk("t3_busy_held", busy_low, 0);
      chk("t3_live_held", live_chg, 0);
      chk("t3_done", cfg_done, 1);
      chk("t3_weights", weights, new_w);
      chk("t3_delays", delays, new_d);
      chk("t3_params", {threshold, decay, refractory_period}, {6'h11, 6'h22, 6'h33});
      exp_w = new_w; exp_d = new_d;
      exp_th = 6'h11; exp_dc = 6'h22; exp_rf = 6'h33;
      tick();
      chk("t3_single_done", cfg_done, 0);

      // Test 6: rx_valid held through the commit cycle
      send(8'h42);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      rx_data  = 8'hC2;
      rx_valid = 1'b1;
      chk("t6_ready_low", rx_ready, 0);
      chk("t6_done", cfg_done, 1);
      chk("t6_params", {threshold, decay, refractory_period}, {6'h01, 6'h02, 6'h03});
      tick();
      chk("t6_ready_high", rx_ready, 1);
      chk("t6_not_yet_cmd", cfg_error, 0);
      tick();
      rx_valid = 1'b0;
      chk("t6_held_as_cmd", cfg_error, 1);
      chk("t6_idle", cfg_busy, 0);
      chk("t6_weights_kept", weights, exp_w);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
